// File: rtl/uart_pkg.sv
// Shared definitions for the Bluetooth serial link: receiver state encoding
// and the command bytes understood by the mode controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic [7:0] CMD_COTTON = 8'h01;
  localparam logic [7:0] CMD_WOODY  = 8'h02;
  localparam logic [7:0] CMD_CITRUS = 8'h03;
  localparam logic [7:0] CMD_T30    = 8'h1E;
  localparam logic [7:0] CMD_T60    = 8'h3C;
  localparam logic [7:0] CMD_T120   = 8'h78;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs (serial line, buttons).
// RESET_VAL lets each user pick the line's idle level.
module rx_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_bt.sv
// 8N1 byte receiver for the Bluetooth serial link. Oversamples rx on clk,
// strobes each good byte out and flags frames whose stop bit is low.
module uart_rx_bt
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       uart_data_valid,
  output logic [7:0] uart_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CLKS  = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CLKS - 1);

  generate
    if (BIT_CLKS < 4) begin : g_bad_baud
      $error("uart_rx_bt: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  logic rx_s;

  rx_synchronizer #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_q, data_n;
  logic             valid_q, valid_n;
  logic             err_q, err_n;
  logic             tick;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_q;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = HALF_LOAD;
        end
      end
      START: begin
        // Re-check the line mid start bit so glitches don't launch a frame
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (!rx_s) begin
          state_n   = DATA;
          cnt_n     = BIT_LOAD;
          bit_idx_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shift_n   = {rx_s, shift[7:1]};
          cnt_n     = BIT_LOAD;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (rx_s) begin
          state_n = IDLE;
          valid_n = 1'b1;
          data_n  = shift;
        end else begin
          state_n = WAIT_HIGH;
          err_n   = 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) reports one error, then waits for idle
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign uart_data_valid = valid_q;
  assign frame_err       = err_q;
  assign uart_data       = data_q;
  assign busy            = (state != IDLE);

endmodule
